pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Program-counter stage that directly consumes the branch adder's target sum.
- Holds the fetch PC and selects the next PC: sequential +4, taken branch/JAL target, JALR target, or trap vector.
- Drives instruction-memory addressing and the IF/ID flush window after a redirect.
- Detects misaligned redirect targets and vectors them to a trap address.

Parameters:
- WIDTH, 32, datapath/PC width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded by reset.
- TRAP_PC, 32'h0000_0100, PC loaded on misaligned redirect target.
- FLUSH_DEPTH, 2, cycles o_flush stays high after an accepted redirect (1..15).

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous active-high reset.
- i_stall  input  1  hazard stall; hold PC.
- i_branch_taken  input  1  resolved taken branch or JAL.
- i_branch_target  input  WIDTH  PC+immediate from branch adder.
- i_jalr  input  1  JALR redirect request.
- i_jalr_target  input  WIDTH  rs1+imm (bit 0 cleared inside this block).
- o_pc  output  WIDTH  current fetch address.
- o_pc_plus4  output  WIDTH  o_pc+4, combinational, modulo 2^WIDTH.
- o_fetch_valid  output  1  o_pc is a valid fetch request.
- o_flush  output  1  kill wrong-path IF/ID contents.
- o_misaligned  output  1  one-cycle pulse: redirect target was misaligned.
- o_bad_target  output  WIDTH  last misaligned target captured.

Behaviour:
Reset (i_rst=1 at edge):
- o_pc=RESET_PC, o_fetch_valid=0, o_flush=0, o_misaligned=0, o_bad_target=0.
- Flush counter=0, state=BOOT.
- Reset overrides every other input.

States:
- BOOT: lasts exactly one cycle; PC holds RESET_PC; o_fetch_valid=0; redirect and stall inputs ignored. Next state RUN with o_fetch_valid=1. o_fetch_valid stays 1 until the next reset.
- RUN: normal operation.
- FLUSH: counter>0, o_flush=1. PC update rules are identical to RUN. Counter decrements every cycle, stalled or not. Counter reaching 0 returns to RUN.

Next-PC priority, evaluated each edge in RUN/FLUSH:
1. i_jalr=1: target = i_jalr_target with bit0 forced 0.
2. else i_branch_taken=1: target = i_branch_target.
3. else i_stall=1: hold o_pc.
4. else: o_pc <= o_pc+4.
- A redirect overrides i_stall.
- Simultaneous i_jalr and i_branch_taken: JALR wins.

Alignment check on redirect target, target[1:0]!=0:
- o_pc <= TRAP_PC.
- o_bad_target <= the selected target after the JALR bit0 clear. A JALR target 0x...3 is captured as 0x...2.
- o_misaligned=1 for the following cycle only.

Accepted redirect (aligned or trap):
- Counter <= FLUSH_DEPTH, state FLUSH.
- o_flush asserts the cycle after the redirect edge, high exactly FLUSH_DEPTH cycles.
- A redirect inside the window reloads the counter to FLUSH_DEPTH, extending the window.

Registering and arithmetic:
- o_flush and o_misaligned are registered; no combinational path from inputs to them.
- o_pc_plus4 is the only combinational output.
- Addition is modulo 2^WIDTH: o_pc=0xFFFF_FFFC, no stall -> next o_pc=0x0000_0000, no flag.
- Reset asserted mid-FLUSH clears the counter and o_flush the next cycle; state returns to BOOT.

Test Plan:
1. Reset release, 4 free-running cycles -> BOOT cycle o_pc=0, fetch_valid=0; then o_pc 0,4,8,C with fetch_valid=1, o_flush=0 throughout.
2. At o_pc=0x10, branch_taken=1, target=0x40 -> next o_pc=0x40, then 0x44, 0x48. o_flush high exactly 2 cycles starting at the 0x40 cycle.
3. i_stall=1 for 3 cycles at o_pc=0x20 -> o_pc holds 0x20. Branch to 0x80 arriving during the stall -> o_pc=0x80 next cycle despite stall.
4. jalr=1, jalr_target=0x103, with branch_taken=1, target=0x200 same cycle -> o_pc=0x102 misaligned. Required: o_pc=TRAP_PC 0x100, o_misaligned one-cycle pulse, o_bad_target=0x102, o_flush 2 cycles.
5. Second branch one cycle into a flush window -> o_flush stays high through 2 cycles after the second redirect (3 total). o_pc follows the second target.
6. Force o_pc=0xFFFF_FFFC via branch, no stall -> o_pc=0x0. Assert i_rst during the following flush -> o_pc=RESET_PC, o_flush=0, one BOOT cycle with fetch_valid=0.

Source files
------------

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch program counter with redirect, trap vectoring and flush window
//
// Ports:
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_stall              hold the fetch PC (a redirect overrides it)
//   i_branch_taken       taken branch/JAL, target on i_branch_target
//   i_jalr               JALR redirect, target on i_jalr_target (bit 0 cleared here)
//   o_pc, o_pc_plus4     fetch address and its combinational +4
//   o_fetch_valid        o_pc is a valid fetch request (low only in the boot cycle)
//   o_flush              kill wrong-path IF/ID contents after a redirect
//   o_misaligned         one-cycle pulse after a misaligned redirect
//   o_bad_target         last misaligned redirect target
module pc_gen #(
  parameter int                 WIDTH       = 32,
  parameter logic [WIDTH-1:0]   RESET_PC    = WIDTH'(32'h0000_0000),
  parameter logic [WIDTH-1:0]   TRAP_PC     = WIDTH'(32'h0000_0100),
  parameter int                 FLUSH_DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_stall,
  input  logic             i_branch_taken,
  input  logic [WIDTH-1:0] i_branch_target,
  input  logic             i_jalr,
  input  logic [WIDTH-1:0] i_jalr_target,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_pc_plus4,
  output logic             o_fetch_valid,
  output logic             o_flush,
  output logic             o_misaligned,
  output logic [WIDTH-1:0] o_bad_target
);

  localparam logic [3:0] DEPTH = 4'(FLUSH_DEPTH);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] flush_cnt;

  logic             redirect;
  logic [WIDTH-1:0] target;
  logic             target_bad;

  assign o_pc_plus4 = o_pc + WIDTH'(4);

  // JALR has priority over a simultaneous branch; its bit 0 is dropped
  // before the alignment check so only bit 1 can make it misaligned.
  always_comb begin
    redirect   = i_jalr | i_branch_taken;
    target     = i_jalr ? (i_jalr_target & ~WIDTH'(1)) : i_branch_target;
    target_bad = (target[1:0] != 2'b00);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= BOOT;
      flush_cnt     <= 4'd0;
      o_pc          <= RESET_PC;
      o_fetch_valid <= 1'b0;
      o_flush       <= 1'b0;
      o_misaligned  <= 1'b0;
      o_bad_target  <= '0;
    end else begin
      case (state)
        BOOT: begin
          // One idle cycle at RESET_PC; redirects and stalls are ignored.
          state         <= RUN;
          o_fetch_valid <= 1'b1;
          o_misaligned  <= 1'b0;
        end
        RUN, FLUSH: begin
          o_misaligned <= 1'b0;
          if (redirect) begin
            // Any accepted redirect (re)starts a full flush window.
            state     <= FLUSH;
            flush_cnt <= DEPTH;
            o_flush   <= 1'b1;
            if (target_bad) begin
              o_pc         <= TRAP_PC;
              o_bad_target <= target;
              o_misaligned <= 1'b1;
            end else begin
              o_pc <= target;
            end
          end else begin
            if (!i_stall) begin
              o_pc <= o_pc_plus4;
            end
            // The window counts down whether or not the PC is stalled.
            if (state == FLUSH) begin
              flush_cnt <= flush_cnt - 4'd1;
              o_flush   <= (flush_cnt != 4'd1);
              state     <= (flush_cnt == 4'd1) ? RUN : FLUSH;
            end
          end
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - randomized and directed self-checking bench for pc_gen
module tb_pc_gen;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RST_PC   = 32'h0000_0000;
  localparam logic [31:0] TRAP_ADR = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br;
  logic [31:0] br_tgt;
  logic        jalr;
  logic [31:0] jalr_tgt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        flush;
  logic        misaligned;
  logic [31:0] bad_target;

  int checks = 0;
  int errors = 0;

  // Reference state: architectural view only.
  logic [31:0] m_pc;
  logic [31:0] m_bad;
  logic        m_mis;
  bit          m_booting;
  int          edge_no;
  int          last_redirect;

  always #5 clk = ~clk;

  pc_gen #(
    .WIDTH      (32),
    .RESET_PC   (RST_PC),
    .TRAP_PC    (TRAP_ADR),
    .FLUSH_DEPTH(DEPTH)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_stall        (stall),
    .i_branch_taken (br),
    .i_branch_target(br_tgt),
    .i_jalr         (jalr),
    .i_jalr_target  (jalr_tgt),
    .o_pc           (pc),
    .o_pc_plus4     (pc_plus4),
    .o_fetch_valid  (fetch_valid),
    .o_flush        (flush),
    .o_misaligned   (misaligned),
    .o_bad_target   (bad_target)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Applies one cycle of inputs, advances the reference model across the
  // edge, then compares every output 1 time unit after the edge.
  task automatic step(input bit r, input bit s, input bit b, input logic [31:0] bt,
                      input bit j, input logic [31:0] jt);
    logic [31:0] tgt;
    bit          exp_flush;
    rst = r; stall = s; br = b; br_tgt = bt; jalr = j; jalr_tgt = jt;
    @(posedge clk);
    edge_no++;
    if (r) begin
      m_pc          = RST_PC;
      m_bad         = 32'h0;
      m_mis         = 1'b0;
      m_booting     = 1'b1;
      last_redirect = -1000;
    end else if (m_booting) begin
      m_booting = 1'b0;
      m_mis     = 1'b0;
    end else if (j || b) begin
      tgt = j ? {jt[31:1], 1'b0} : bt;
      if (tgt % 4 != 0) begin
        m_pc  = TRAP_ADR;
        m_bad = tgt;
        m_mis = 1'b1;
      end else begin
        m_pc  = tgt;
        m_mis = 1'b0;
      end
      last_redirect = edge_no;
    end else begin
      m_mis = 1'b0;
      if (!s) m_pc = m_pc + 32'd4;
    end
    exp_flush = (edge_no - last_redirect >= 0) && (edge_no - last_redirect < DEPTH);
    #1;
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("fetch_valid", {31'b0, fetch_valid}, {31'b0, !m_booting});
    check("flush", {31'b0, flush}, {31'b0, exp_flush});
    check("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
    check("bad_target", bad_target, m_bad);
  endtask

  task automatic idle();
    step(0, 0, 0, 32'h0, 0, 32'h0);
  endtask

  initial begin
    edge_no = 0; last_redirect = -1000;
    m_pc = RST_PC; m_bad = 0; m_mis = 0; m_booting = 1'b1;

    // 1: reset, boot cycle, free run
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 32'h44, 1, 32'h88);
    check("t1_boot_valid", {31'b0, fetch_valid}, 32'd0);
    check("t1_boot_pc", pc, 32'h0);
    step(0, 1, 1, 32'h500, 0, 0);        // boot ignores redirect/stall
    check("t1_pc0", pc, 32'h0);
    idle(); check("t1_pc4", pc, 32'h4);
    idle(); check("t1_pc8", pc, 32'h8);
    idle(); check("t1_pcC", pc, 32'hC);
    idle(); check("t1_pc10", pc, 32'h10);

    // 2: branch to 0x40, two-cycle flush
    step(0, 0, 1, 32'h40, 0, 0);
    check("t2_pc40", pc, 32'h40); check("t2_flush1", {31'b0, flush}, 32'd1);
    idle(); check("t2_pc44", pc, 32'h44); check("t2_flush2", {31'b0, flush}, 32'd1);
    idle(); check("t2_pc48", pc, 32'h48); check("t2_flush_off", {31'b0, flush}, 32'd0);

    // 3: stall at 0x20, then branch during stall
    step(0, 0, 1, 32'h1C, 0, 0);
    idle(); check("t3_pc20", pc, 32'h20);
    repeat (3) begin
      step(0, 1, 0, 0, 0, 0); check("t3_hold", pc, 32'h20);
    end
    step(0, 1, 1, 32'h80, 0, 0); check("t3_pc80", pc, 32'h80);

    // 4: JALR beats branch, misaligned after bit-0 clear -> trap
    step(0, 0, 1, 32'h200, 1, 32'h103);
    check("t4_trap", pc, TRAP_ADR);
    check("t4_mis", {31'b0, misaligned}, 32'd1);
    check("t4_bad", bad_target, 32'h102);
    idle(); check("t4_mis_pulse", {31'b0, misaligned}, 32'd0);
    check("t4_flush", {31'b0, flush}, 32'd1);
    idle(); idle();

    // 5: second redirect inside the window extends it
    step(0, 0, 1, 32'h300, 0, 0);
    step(0, 0, 1, 32'h400, 0, 0); check("t5_pc", pc, 32'h400);
    idle(); check("t5_flush_ext", {31'b0, flush}, 32'd1);
    idle(); check("t5_flush_end", {31'b0, flush}, 32'd0);

    // 6: wraparound, then reset during the flush window
    step(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    check("t6_plus4_wrap", pc_plus4, 32'h0);
    idle(); check("t6_wrap", pc, 32'h0); check("t6_nomis", {31'b0, misaligned}, 32'd0);
    step(1, 0, 1, 32'h40, 0, 0);
    check("t6_rst_pc", pc, RST_PC); check("t6_rst_flush", {31'b0, flush}, 32'd0);
    check("t6_rst_valid", {31'b0, fetch_valid}, 32'd0);
    idle(); check("t6_run_valid", {31'b0, fetch_valid}, 32'd1);

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] bt, jt;
      bt = $urandom; jt = $urandom;
      if ($urandom_range(0, 1) == 0) bt = bt & 32'hFFFF_FFFC;
      if ($urandom_range(0, 1) == 0) jt = jt & 32'hFFFF_FFFD;
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) < 2,
           bt,
           $urandom_range(0, 9) == 0,
           jt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
